// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared UART encodings, line-level constants and word-length
//            helper used by the transmit datapath and its sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Line-control word-length field encodings
  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_e;

  // Serial line levels
  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;

  // Number of data bits carried by a character for a given wls field
  function automatic logic [3:0] word_len(input logic [1:0] wls);
    logic [3:0] len;
    case (wls_e'(wls))
      WLS_5:   len = 4'd5;
      WLS_6:   len = 4'd6;
      WLS_7:   len = 4'd7;
      default: len = 4'd8;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Divisor counter producing a one-cycle end-of-bit strobe.
//            The active divisor is captured while cleared and at each wrap,
//            so a divisor change mid-frame only lands at a bit boundary.
//            A divisor of zero parks the counter and suppresses the strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             i_enable,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_edge
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             w_wrap;

  // Strobe on the last cycle of a bit period; clear and soft reset suppress it
  assign w_wrap = i_enable && !i_clr && (r_div != '0) &&
                  (r_cnt == (r_div - DIV_W'(1)));
  assign o_edge = w_wrap;

  // Bit-period counter with divisor capture at clear, wrap or while parked
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (!i_enable || i_clr) begin
      r_cnt <= '0;
      r_div <= i_divisor;
    end else if (r_div == '0) begin
      r_cnt <= '0;
      r_div <= i_divisor;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_div <= i_divisor;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_datapath.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_datapath
// Purpose  : UART transmit datapath slaved to the transmit FSM. Generates the
//            bit strobe, loads/serialises the character, computes parity,
//            drives the registered serial line and reports bit-position
//            status back to the FSM.
// Options  : UART_TX_BREAK_EN - when defined, brk forces txd low while the
//            frame continues underneath; when undefined brk is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_datapath #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             utrst,
  input  logic [7:0]       thr_data,
  input  logic [1:0]       wls,
  input  logic             pen,
  input  logic             eps,
  input  logic             stb,
  input  logic             brk,
  input  logic [DIV_W-1:0] divisor,
  input  logic             transmit_clk_clr,
  input  logic             tsr_load,
  input  logic             shift_en,
  input  logic             shift_count_en,
  input  logic             shift_count_clr,
  input  logic             par,
  input  logic             not_op,
  output logic             transmit_edge,
  output logic             data_cnt_eq,
  output logic             shift_cnt_eq,
  output logic             txd,
  output logic             tx_busy
);

  import uart_pkg::*;

  logic [3:0]       w_word_len;
  logic [CNT_W-1:0] w_n_cnt;
  logic [CNT_W-1:0] w_frame_len;
  logic [7:0]       w_data_mask;
  logic [7:0]       w_load_val;
  logic             w_par_calc;
  logic             w_txd_next;
  logic             w_txd_d;

  logic [7:0]       r_tsr;
  logic             r_par;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_txd;

  assign w_word_len  = word_len(wls);
  assign w_n_cnt     = CNT_W'(w_word_len);
  // start + data + optional parity + one or two stop bits
  assign w_frame_len = CNT_W'(32'(w_word_len) + 32'(pen) + 32'(stb) + 32'd2);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_enable  (utrst),
    .i_clr     (transmit_clk_clr),
    .i_divisor (divisor),
    .o_edge    (transmit_edge)
  );

  // Mask of the active data bits; bits above the word length become ones
  always_comb begin
    w_data_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_data_mask[i] = (i < int'(w_word_len));
    end
  end

  // Ones-fill above the word supplies the stop bits as the TSR drains
  assign w_load_val = thr_data | ~w_data_mask;
  // Even parity is the plain XOR of the data bits; odd parity inverts it
  assign w_par_calc = (^(thr_data & w_data_mask)) ^ ~eps;

  // Line value for the next cycle, one pclk behind the FSM state
  always_comb begin
    w_txd_next = r_tsr[0];
    if (transmit_clk_clr) begin
      w_txd_next = TXD_IDLE;
    end else if (not_op) begin
      w_txd_next = TXD_START;
    end else if (par) begin
      w_txd_next = r_par;
    end
  end

`ifdef UART_TX_BREAK_EN
  assign w_txd_d = brk ? 1'b0 : w_txd_next;
`else
  logic w_brk_unused;
  assign w_brk_unused = brk;
  assign w_txd_d      = w_txd_next;
`endif

  // Transmit shift register and captured parity bit; load wins over shift
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tsr <= 8'hFF;
      r_par <= 1'b0;
    end else if (!utrst) begin
      r_tsr <= 8'hFF;
      r_par <= 1'b0;
    end else if (tsr_load) begin
      r_tsr <= w_load_val;
      r_par <= w_par_calc;
    end else if (shift_en) begin
      r_tsr <= {1'b1, r_tsr[7:1]};
    end
  end

  // Completed-bit counter: clear wins, increment saturates at all-ones
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_bit_cnt <= '0;
    end else if (!utrst) begin
      r_bit_cnt <= '0;
    end else if (shift_count_clr) begin
      r_bit_cnt <= '0;
    end else if (shift_count_en && (r_bit_cnt != {CNT_W{1'b1}})) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Registered serial output
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_txd <= TXD_IDLE;
    end else if (!utrst) begin
      r_txd <= TXD_IDLE;
    end else begin
      r_txd <= w_txd_d;
    end
  end

  assign data_cnt_eq  = pen && (r_bit_cnt == w_n_cnt);
  assign shift_cnt_eq = (r_bit_cnt == w_frame_len);
  assign txd          = r_txd;
  assign tx_busy      = !transmit_clk_clr;

endmodule
`default_nettype wire
